// File: rtl/guess_checker_if.sv
// Bus bundle between the guess checker and its environment (keypad, digit generator, display).
interface guess_checker_if;
    logic       start;
    logic [3:0] tgt_d0;
    logic [3:0] tgt_d1;
    logic [3:0] tgt_d2;
    logic [3:0] tgt_d3;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic       clear;

    logic       seed_en;
    logic       busy;
    logic [2:0] entry_count;
    logic [3:0] guess_d0;
    logic [3:0] guess_d1;
    logic [3:0] guess_d2;
    logic [3:0] guess_d3;
    logic [3:0] hit;
    logic [2:0] exact;
    logic       result_valid;
    logic       bad_digit;
    logic [3:0] tries;
    logic       win;
    logic       lose;

    modport master (
        output start, tgt_d0, tgt_d1, tgt_d2, tgt_d3, digit_valid, digit_in, clear,
        input  seed_en, busy, entry_count, guess_d0, guess_d1, guess_d2, guess_d3,
               hit, exact, result_valid, bad_digit, tries, win, lose
    );

    modport slave (
        input  start, tgt_d0, tgt_d1, tgt_d2, tgt_d3, digit_valid, digit_in, clear,
        output seed_en, busy, entry_count, guess_d0, guess_d1, guess_d2, guess_d3,
               hit, exact, result_valid, bad_digit, tries, win, lose
    );
endinterface

// File: rtl/guess_checker.sv
// Four-digit guessing game: seeds the target generator, collects guesses, scores them.
module guess_checker #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           rst,
    guess_checker_if.slave bus
);
    localparam int unsigned DW = 4;
    localparam int unsigned ND = 4;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        IDLE, SEED, WAIT1, WAIT2, ENTRY, CHECK, RESULT, DONE
    } state_t;

    state_t                   state, state_nxt;
    logic                     seed_en_q, seed_en_n;
    logic                     busy_q, busy_n;
    logic                     result_valid_q, result_valid_n;
    logic                     bad_digit_q, bad_digit_n;
    logic                     win_q, win_n;
    logic                     lose_q, lose_n;
    logic [CW-1:0]            cnt_q, cnt_n;
    logic [ND-1:0][DW-1:0]    guess_q, guess_n;
    logic [ND-1:0][DW-1:0]    target_q, target_n;
    logic [ND-1:0]            hit_q, hit_n, hit_c;
    logic [CW-1:0]            exact_q, exact_n, exact_c;
    logic [DW-1:0]            tries_q, tries_n;

    // Per-position score of the current guess against the latched target (10 = wildcard).
    always_comb begin
        hit_c   = '0;
        exact_c = '0;
        for (int i = 0; i < int'(ND); i++) begin
            hit_c[i] = (target_q[i] == DW'(10)) || (target_q[i] == guess_q[i]);
            exact_c  = exact_c + CW'(hit_c[i]);
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            seed_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            bad_digit_q    <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            cnt_q          <= '0;
            guess_q        <= '0;
            target_q       <= '0;
            hit_q          <= '0;
            exact_q        <= '0;
            tries_q        <= '0;
        end else begin
            state          <= state_nxt;
            seed_en_q      <= seed_en_n;
            busy_q         <= busy_n;
            result_valid_q <= result_valid_n;
            bad_digit_q    <= bad_digit_n;
            win_q          <= win_n;
            lose_q         <= lose_n;
            cnt_q          <= cnt_n;
            guess_q        <= guess_n;
            target_q       <= target_n;
            hit_q          <= hit_n;
            exact_q        <= exact_n;
            tries_q        <= tries_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        result_valid_n = 1'b0;
        bad_digit_n    = 1'b0;
        win_n          = win_q;
        lose_n         = lose_q;
        cnt_n          = cnt_q;
        guess_n        = guess_q;
        target_n       = target_q;
        hit_n          = hit_q;
        exact_n        = exact_q;
        tries_n        = tries_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = SEED;
                    tries_n   = '0;
                    cnt_n     = '0;
                    win_n     = 1'b0;
                    lose_n    = 1'b0;
                end
            end
            SEED:  state_nxt = WAIT1;
            WAIT1: state_nxt = WAIT2;
            WAIT2: begin
                state_nxt = ENTRY;
                target_n  = {bus.tgt_d3, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0};
            end
            ENTRY: begin
                if (bus.clear) begin
                    cnt_n   = '0;
                    guess_n = '0;
                end else if (bus.digit_valid) begin
                    if (bus.digit_in <= DW'(9)) begin
                        guess_n[cnt_q[1:0]] = bus.digit_in;
                        cnt_n               = cnt_q + CW'(1);
                        if (cnt_q == CW'(3)) begin
                            state_nxt = CHECK;
                        end
                    end else begin
                        bad_digit_n = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_nxt = RESULT;
                hit_n     = hit_c;
                exact_n   = exact_c;
                if (tries_q != DW'(15)) begin
                    tries_n = tries_q + DW'(1);
                end
            end
            RESULT: begin
                result_valid_n = 1'b1;
                if (exact_q == CW'(4)) begin
                    win_n     = 1'b1;
                    state_nxt = DONE;
                end else if (tries_q == DW'(MAX_TRIES)) begin
                    lose_n    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_n     = '0;
                    state_nxt = ENTRY;
                end
            end
            default: state_nxt = IDLE;
        endcase

        seed_en_n = (state_nxt == SEED);
        busy_n    = (state_nxt != IDLE) && (state_nxt != DONE);
    end

    assign bus.seed_en      = seed_en_q;
    assign bus.busy         = busy_q;
    assign bus.entry_count  = cnt_q;
    assign bus.guess_d0     = guess_q[0];
    assign bus.guess_d1     = guess_q[1];
    assign bus.guess_d2     = guess_q[2];
    assign bus.guess_d3     = guess_q[3];
    assign bus.hit          = hit_q;
    assign bus.exact        = exact_q;
    assign bus.result_valid = result_valid_q;
    assign bus.bad_digit    = bad_digit_q;
    assign bus.tries        = tries_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with a result scoreboard.
module tb_guess_checker;
    localparam int unsigned MAX_TRIES = 2;

    typedef struct packed {
        logic [3:0] hit;
        logic [2:0] exact;
        logic [3:0] tries;
        logic       win;
        logic       lose;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    guess_checker_if bus ();

    guess_checker #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] tgt_m[4];
    int         tries_m  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tgt(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        bus.tgt_d0 = a; bus.tgt_d1 = b; bus.tgt_d2 = c; bus.tgt_d3 = d;
        tgt_m[0] = a; tgt_m[1] = b; tgt_m[2] = c; tgt_m[3] = d;
    endtask

    task automatic digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit_in    = d;
        step();
        bus.digit_valid = 1'b0;
    endtask

    // Scores the guess with a reference model, queues the expectation, then keys it in.
    task automatic guess(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] g[4];
        exp_t       e;
        g[0] = a; g[1] = b; g[2] = c; g[3] = d;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            if (tgt_m[i] == 4'd10 || tgt_m[i] == g[i]) begin
                e.hit[i] = 1'b1;
                e.exact  = e.exact + 3'd1;
            end
        end
        if (tries_m < 15) tries_m++;
        e.tries = 4'(tries_m);
        e.win   = (e.exact == 3'd4);
        e.lose  = !e.win && (tries_m == int'(MAX_TRIES));
        sb.push_back(e);
        for (int i = 0; i < 4; i++) digit(g[i]);
    endtask

    // Waits (bounded) for result_valid, checks latency, then pops and compares.
    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.result_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_hit"},   32'(bus.hit),   32'(e.hit));
            chk({tag, "_exact"}, 32'(bus.exact), 32'(e.exact));
            chk({tag, "_tries"}, 32'(bus.tries), 32'(e.tries));
            chk({tag, "_win"},   32'(bus.win),   32'(e.win));
            chk({tag, "_lose"},  32'(bus.lose),  32'(e.lose));
        end
    endtask

    task automatic new_game(input string tag);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tries_m = 0;
        chk({tag, "_seed_en_on"}, 32'(bus.seed_en), 32'd1);
        chk({tag, "_busy"},       32'(bus.busy),    32'd1);
        chk({tag, "_tries_clr"},  32'(bus.tries),   32'd0);
        chk({tag, "_win_clr"},    32'(bus.win),     32'd0);
        chk({tag, "_lose_clr"},   32'(bus.lose),    32'd0);
        step();
        chk({tag, "_seed_en_off"}, 32'(bus.seed_en), 32'd0);
        step();
        step();
        chk({tag, "_entry_busy"}, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit_in    = '0;
        bus.clear       = 1'b0;
        set_tgt(4'd3, 4'd7, 4'd1, 4'd9);
        step();
        step();

        chk("rst_busy",    32'(bus.busy),        32'd0);
        chk("rst_seed_en", 32'(bus.seed_en),     32'd0);
        chk("rst_count",   32'(bus.entry_count), 32'd0);
        chk("rst_tries",   32'(bus.tries),       32'd0);
        chk("rst_hit",     32'(bus.hit),         32'd0);
        chk("rst_exact",   32'(bus.exact),       32'd0);
        chk("rst_winlose", 32'({bus.win, bus.lose}), 32'd0);
        rst = 1'b0;
        step();

        // Game 1: exact match on the first try.
        new_game("g1");
        set_tgt(4'd0, 4'd0, 4'd0, 4'd0);
        tgt_m[0] = 4'd3; tgt_m[1] = 4'd7; tgt_m[2] = 4'd1; tgt_m[3] = 4'd9;
        guess(4'd3, 4'd7, 4'd1, 4'd9);
        wait_result("g1");
        chk("g1_done_busy", 32'(bus.busy), 32'd0);
        step();
        chk("g1_rv_pulse", 32'(bus.result_valid), 32'd0);
        digit(4'd5);
        chk("g1_done_ignore", 32'(bus.entry_count), 32'd4);
        chk("g1_hit_hold",    32'(bus.hit),         32'd15);

        // Game 2: wildcards, bad digit, clear, start while busy, then lose.
        set_tgt(4'd10, 4'd2, 4'd10, 4'd5);
        new_game("g2");
        digit(4'd12);
        chk("g2_bad_pulse", 32'(bus.bad_digit),   32'd1);
        chk("g2_bad_count", 32'(bus.entry_count), 32'd0);
        step();
        chk("g2_bad_end",   32'(bus.bad_digit),   32'd0);
        digit(4'd5);
        digit(4'd6);
        chk("g2_count2",    32'(bus.entry_count), 32'd2);
        bus.clear = 1'b1;
        digit(4'd4);
        bus.clear = 1'b0;
        chk("g2_clear_count", 32'(bus.entry_count), 32'd0);
        chk("g2_clear_d0",    32'(bus.guess_d0),    32'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("g2_start_busy_seed", 32'(bus.seed_en), 32'd0);
        chk("g2_start_busy_busy", 32'(bus.busy),    32'd1);
        guess(4'd8, 4'd2, 4'd0, 4'd4);
        wait_result("g2a");
        chk("g2a_count0", 32'(bus.entry_count), 32'd0);
        chk("g2a_busy",   32'(bus.busy),        32'd1);
        guess(4'd0, 4'd0, 4'd0, 4'd0);
        wait_result("g2b");
        chk("g2b_busy", 32'(bus.busy), 32'd0);
        digit(4'd1);
        chk("g2b_ignore_count", 32'(bus.entry_count), 32'd4);
        chk("g2b_hit_hold",     32'(bus.hit),         32'd5);
        chk("g2b_lose_hold",    32'(bus.lose),        32'd1);

        // Game 3: reset mid-guess aborts silently, then a fresh game.
        set_tgt(4'd1, 4'd2, 4'd3, 4'd4);
        new_game("g3");
        digit(4'd1);
        digit(4'd2);
        digit(4'd3);
        rst = 1'b1;
        #1;
        chk("g3_rst_busy",  32'(bus.busy),        32'd0);
        chk("g3_rst_count", 32'(bus.entry_count), 32'd0);
        chk("g3_rst_d0",    32'(bus.guess_d0),    32'd0);
        chk("g3_rst_hit",   32'(bus.hit),         32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("g3_rst_no_rv", 32'(bus.result_valid), 32'd0);
        end
        rst = 1'b0;
        new_game("g4");
        guess(4'd1, 4'd2, 4'd3, 4'd4);
        wait_result("g4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
